// File: rtl/i2c_apb_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_apb_ctrl : APB register bank, TX/RX FIFOs and transaction sequencer
//                that drives the I2C master byte engine.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module i2c_apb_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       PCLK_i,
  input  logic       PRESET_N_i,
  input  logic       PSEL_i,
  input  logic       PENABLE_i,
  input  logic       PWRITE_i,
  input  logic [7:0] PADDR_i,
  input  logic [7:0] PWDATA_i,
  output logic [7:0] PRDATA_o,
  output logic       PREADY_o,
  output logic       PSLVERR_o,
  output logic       CORE_CMD_VALID_o,
  output logic [1:0] CORE_CMD_o,
  output logic [7:0] CORE_DATA_o,
  output logic       CORE_LAST_o,
  input  logic       CORE_CMD_READY_i,
  input  logic       CORE_DONE_i,
  input  logic       CORE_ACK_ERR_i,
  input  logic [7:0] CORE_RDATA_i,
  output logic       INT_o
);

  localparam int             AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]  PTR_ONE     = AW'(1);
  localparam logic [AW:0]    CNT_ONE     = (AW+1)'(1);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_SADDR  = 8'h01;
  localparam logic [7:0] ADDR_LEN    = 8'h02;
  localparam logic [7:0] ADDR_TXDATA = 8'h03;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h05;
  localparam logic [7:0] ADDR_CMD    = 8'h06;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_START      = 4'd1,
    S_WAIT_START = 4'd2,
    S_WRITE      = 4'd3,
    S_WAIT_WR    = 4'd4,
    S_READ       = 4'd5,
    S_WAIT_RD    = 4'd6,
    S_STOP       = 4'd7,
    S_WAIT_STOP  = 4'd8
  } state_t;

  state_t      state, state_nxt;

  logic        ctrl_en, ctrl_irq_en, ctrl_rw;
  logic [6:0]  saddr;
  logic [7:0]  len;
  logic        st_done, st_nack, st_ovf;
  logic [6:0]  xfer_saddr;
  logic        xfer_rw;
  logic [7:0]  byte_cnt;
  logic        int_q;
  logic [7:0]  prdata_q;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [AW:0] tx_count;
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [AW:0] rx_count;

  logic        apb_setup_rd, apb_access, wr_access, rd_access, unmapped;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push_req, tx_push, tx_pop;
  logic        rx_pop_req, rx_pop, rx_push, rx_push_req;
  logic        ovf_set, cmd_accept, cmd_fire, busy;
  logic        nack_set, done_set, cnt_load, cnt_dec;
  logic [7:0]  status_vec, rd_mux;

  assign apb_setup_rd = PSEL_i & ~PENABLE_i & ~PWRITE_i;
  assign apb_access   = PSEL_i & PENABLE_i;
  assign wr_access    = apb_access & PWRITE_i;
  assign rd_access    = apb_access & ~PWRITE_i;
  assign unmapped     = (PADDR_i > ADDR_CMD);

  assign PREADY_o  = apb_access;
  assign PSLVERR_o = apb_access & unmapped;
  assign PRDATA_o  = prdata_q;
  assign INT_o     = int_q;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  assign busy     = (state != S_IDLE);
  assign cmd_fire = CORE_CMD_VALID_o & CORE_CMD_READY_i;

  assign tx_push_req = wr_access & (PADDR_i == ADDR_TXDATA);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = (state == S_WRITE) & cmd_fire;

  assign rx_push_req = (state == S_WAIT_RD) & CORE_DONE_i;
  assign rx_push     = rx_push_req & ~rx_full;
  assign rx_pop_req  = rd_access & (PADDR_i == ADDR_RXDATA);
  assign rx_pop      = rx_pop_req & ~rx_empty;

  assign ovf_set = (tx_push_req & tx_full) | (rx_pop_req & rx_empty) | (rx_push_req & rx_full);

  assign cmd_accept = wr_access & (PADDR_i == ADDR_CMD) & PWDATA_i[0] & ctrl_en & ~busy;

  assign status_vec = {st_ovf, rx_empty, rx_full, tx_empty, tx_full, st_nack, st_done, busy};

  always_comb begin
    rd_mux = 8'h00;
    case (PADDR_i)
      ADDR_CTRL:   rd_mux = {5'b0, ctrl_rw, ctrl_irq_en, ctrl_en};
      ADDR_SADDR:  rd_mux = {1'b0, saddr};
      ADDR_LEN:    rd_mux = len;
      ADDR_RXDATA: rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rptr];
      ADDR_STATUS: rd_mux = status_vec;
      default:     rd_mux = 8'h00;
    endcase
  end

  // Register bank; hardware sets win over software W1C in the same cycle.
  always_ff @(posedge PCLK_i or negedge PRESET_N_i) begin
    if (!PRESET_N_i) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_rw     <= 1'b0;
      saddr       <= 7'h00;
      len         <= 8'h00;
      st_done     <= 1'b0;
      st_nack     <= 1'b0;
      st_ovf      <= 1'b0;
      prdata_q    <= 8'h00;
      int_q       <= 1'b0;
    end else begin
      if (wr_access && PADDR_i == ADDR_CTRL) begin
        ctrl_en     <= PWDATA_i[0];
        ctrl_irq_en <= PWDATA_i[1];
        ctrl_rw     <= PWDATA_i[2];
      end
      if (wr_access && PADDR_i == ADDR_SADDR) saddr <= PWDATA_i[6:0];
      if (wr_access && PADDR_i == ADDR_LEN)   len   <= PWDATA_i;
      if (wr_access && PADDR_i == ADDR_STATUS) begin
        st_done <= (st_done & ~PWDATA_i[1]) | done_set;
        st_nack <= (st_nack & ~PWDATA_i[2]) | nack_set;
        st_ovf  <= (st_ovf  & ~PWDATA_i[7]) | ovf_set;
      end else begin
        st_done <= st_done | done_set;
        st_nack <= st_nack | nack_set;
        st_ovf  <= st_ovf  | ovf_set;
      end
      if (apb_setup_rd) prdata_q <= rd_mux;
      int_q <= ctrl_irq_en & (st_done | st_nack);
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (tx_push) tx_mem[tx_wptr] <= PWDATA_i;
    if (rx_push) rx_mem[rx_wptr] <= CORE_RDATA_i;
  end

  always_ff @(posedge PCLK_i or negedge PRESET_N_i) begin
    if (!PRESET_N_i) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Address and direction are captured at CMD so software edits mid-transfer
  // cannot disturb the command fields presented to the engine.
  always_ff @(posedge PCLK_i or negedge PRESET_N_i) begin
    if (!PRESET_N_i) begin
      state      <= S_IDLE;
      byte_cnt   <= 8'h00;
      xfer_saddr <= 7'h00;
      xfer_rw    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_load) begin
        byte_cnt   <= len;
        xfer_saddr <= saddr;
        xfer_rw    <= ctrl_rw;
      end else if (cnt_dec) begin
        byte_cnt <= byte_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    CORE_CMD_VALID_o = 1'b0;
    CORE_CMD_o       = CMD_START;
    CORE_DATA_o      = 8'h00;
    CORE_LAST_o      = 1'b0;
    nack_set         = 1'b0;
    done_set         = 1'b0;
    cnt_load         = 1'b0;
    cnt_dec          = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_accept) begin
          state_nxt = S_START;
          cnt_load  = 1'b1;
        end
      end
      S_START: begin
        CORE_CMD_VALID_o = 1'b1;
        CORE_CMD_o       = CMD_START;
        CORE_DATA_o      = {xfer_saddr, xfer_rw};
        if (CORE_CMD_READY_i) state_nxt = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (CORE_DONE_i) begin
          if (CORE_ACK_ERR_i) begin
            state_nxt = S_STOP;
            nack_set  = 1'b1;
          end else if (byte_cnt == 8'd0 || !ctrl_en) begin
            state_nxt = S_STOP;
          end else begin
            state_nxt = xfer_rw ? S_READ : S_WRITE;
          end
        end
      end
      S_WRITE: begin
        CORE_CMD_VALID_o = ~tx_empty;
        CORE_CMD_o       = CMD_WRITE;
        CORE_DATA_o      = tx_mem[tx_rptr];
        if (!tx_empty && CORE_CMD_READY_i) state_nxt = S_WAIT_WR;
        else if (tx_empty && !ctrl_en)     state_nxt = S_STOP;
      end
      S_WAIT_WR: begin
        if (CORE_DONE_i) begin
          cnt_dec = 1'b1;
          if (CORE_ACK_ERR_i) begin
            state_nxt = S_STOP;
            nack_set  = 1'b1;
          end else if (byte_cnt == 8'd1 || !ctrl_en) begin
            state_nxt = S_STOP;
          end else begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_READ: begin
        CORE_CMD_VALID_o = ~rx_full;
        CORE_CMD_o       = CMD_READ;
        CORE_LAST_o      = (byte_cnt == 8'd1);
        if (!rx_full && CORE_CMD_READY_i) state_nxt = S_WAIT_RD;
        else if (rx_full && !ctrl_en)     state_nxt = S_STOP;
      end
      S_WAIT_RD: begin
        if (CORE_DONE_i) begin
          cnt_dec = 1'b1;
          if (byte_cnt == 8'd1 || !ctrl_en) state_nxt = S_STOP;
          else                              state_nxt = S_READ;
        end
      end
      S_STOP: begin
        CORE_CMD_VALID_o = 1'b1;
        CORE_CMD_o       = CMD_STOP;
        if (CORE_CMD_READY_i) state_nxt = S_WAIT_STOP;
      end
      S_WAIT_STOP: begin
        if (CORE_DONE_i) begin
          state_nxt = S_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_apb_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_apb_ctrl : directed bench with a behavioural byte engine.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_i2c_apb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic       cvalid, clast, cready, cdone, cackerr;
  logic [1:0] ccmd;
  logic [7:0] cdata, crdata;
  logic       irq;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] data;
    logic       last;
  } ent_t;

  ent_t       log_q[$];
  logic [7:0] rd_q[$];
  logic       nack_on_start = 1'b0;

  always #5 clk = ~clk;

  i2c_apb_ctrl #(.FIFO_DEPTH(4)) dut (
    .PCLK_i(clk), .PRESET_N_i(rst_n),
    .PSEL_i(psel), .PENABLE_i(penable), .PWRITE_i(pwrite),
    .PADDR_i(paddr), .PWDATA_i(pwdata), .PRDATA_o(prdata),
    .PREADY_o(pready), .PSLVERR_o(pslverr),
    .CORE_CMD_VALID_o(cvalid), .CORE_CMD_o(ccmd), .CORE_DATA_o(cdata),
    .CORE_LAST_o(clast), .CORE_CMD_READY_i(cready), .CORE_DONE_i(cdone),
    .CORE_ACK_ERR_i(cackerr), .CORE_RDATA_i(crdata), .INT_o(irq)
  );

  // Byte engine: accept one cycle after VALID is seen, DONE two cycles later.
  initial begin : engine
    ent_t e;
    cready = 1'b0; cdone = 1'b0; cackerr = 1'b0; crdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cvalid === 1'b1) begin
        e = {ccmd, cdata, clast};
        log_q.push_back(e);
        cready = 1'b1;
        @(posedge clk); #1 cready = 1'b0;
        @(posedge clk); #1;
        cdone   = 1'b1;
        cackerr = (e.cmd == 2'b00) && nack_on_start;
        crdata  = 8'h00;
        if (e.cmd == 2'b10 && rd_q.size() > 0) crdata = rd_q.pop_front();
        @(posedge clk); #1 cdone = 1'b0; cackerr = 1'b0;
      end
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d, output logic err);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1'b1;
    #1 err = pslverr;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic err);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1;
    #1 d = prdata; err = pslverr;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic [7:0] s;
    logic e;
    s = 8'hFF;
    for (int k = 0; k < 100; k++) begin
      apb_read(8'h05, s, e);
      if (s[0] == 1'b0) break;
    end
    n_cmp++;
    if (s[0] !== 1'b0) begin
      n_err++; $display("FAIL %s_idle: busy=%b required 0 (timeout)", nm, s[0]);
    end
  endtask

  task automatic test_reset;
    logic [7:0] s; logic e;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({cvalid, ccmd, cdata, clast} !== 12'h000) begin
      n_err++; $display("FAIL rst_core: got %h required 000", {cvalid, ccmd, cdata, clast}); end
    n_cmp++; if ({prdata, pslverr, irq} !== 10'h000) begin
      n_err++; $display("FAIL rst_apb: got %h required 000", {prdata, pslverr, irq}); end
    @(negedge clk); rst_n = 1'b1;
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h50) begin n_err++; $display("FAIL rst_status: got %h required 50", s); end
    apb_read(8'h00, s, e);
    n_cmp++; if (s !== 8'h00) begin n_err++; $display("FAIL rst_ctrl: got %h required 00", s); end
  endtask

  task automatic test_write;
    logic [7:0] s; logic e;
    logic [1:0] ec [4];
    logic [7:0] ed [4];
    ec = '{2'd0, 2'd1, 2'd1, 2'd3};
    ed = '{8'hA0, 8'hA1, 8'hB2, 8'h00};
    apb_write(8'h02, 8'd2, e);
    apb_write(8'h01, 8'h50, e);
    apb_write(8'h03, 8'hA1, e);
    apb_write(8'h03, 8'hB2, e);
    apb_write(8'h00, 8'h03, e);
    log_q.delete();
    apb_write(8'h06, 8'h01, e);
    wait_idle("wr");
    n_cmp++; if (log_q.size() != 4) begin
      n_err++; $display("FAIL wr_count: got %0d commands required 4", log_q.size()); end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].cmd !== ec[i] || (ec[i] < 2'd2 && log_q[i].data !== ed[i])) begin
        n_err++; $display("FAIL wr_cmd[%0d]: got cmd=%0d data=%h required cmd=%0d data=%h",
                          i, log_q[i].cmd, log_q[i].data, ec[i], ed[i]); end
    end
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h52) begin n_err++; $display("FAIL wr_status: got %h required 52", s); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL wr_int: got %b required 1", irq); end
    apb_write(8'h05, 8'h02, e);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL wr_int_clr: got %b required 0", irq); end
  endtask

  task automatic test_read;
    logic [7:0] s; logic e;
    logic [1:0] ec [5];
    logic       el [5];
    logic [7:0] er [4];
    ec = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd3};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    er = '{8'h11, 8'h22, 8'h33, 8'h00};
    rd_q = '{8'h11, 8'h22, 8'h33};
    apb_write(8'h02, 8'd3, e);
    apb_write(8'h01, 8'h21, e);
    apb_write(8'h00, 8'h07, e);
    log_q.delete();
    apb_write(8'h06, 8'h01, e);
    wait_idle("rd");
    n_cmp++; if (log_q.size() != 5) begin
      n_err++; $display("FAIL rd_count: got %0d commands required 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].cmd !== ec[i] || (i == 0 && log_q[i].data !== 8'h43) ||
          (ec[i] == 2'd2 && log_q[i].last !== el[i])) begin
        n_err++; $display("FAIL rd_cmd[%0d]: got cmd=%0d data=%h last=%b required cmd=%0d last=%b",
                          i, log_q[i].cmd, log_q[i].data, log_q[i].last, ec[i], el[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      apb_read(8'h04, s, e);
      n_cmp++; if (s !== er[i]) begin
        n_err++; $display("FAIL rd_rxdata[%0d]: got %h required %h", i, s, er[i]); end
    end
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'hD2) begin n_err++; $display("FAIL rd_status: got %h required D2", s); end
    apb_write(8'h05, 8'h82, e);
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h50) begin n_err++; $display("FAIL rd_w1c: got %h required 50", s); end
  endtask

  task automatic test_nack;
    logic [7:0] s; logic e;
    apb_write(8'h00, 8'h01, e);
    apb_write(8'h02, 8'd1, e);
    apb_write(8'h03, 8'h55, e);
    nack_on_start = 1'b1;
    log_q.delete();
    apb_write(8'h06, 8'h01, e);
    wait_idle("nack");
    nack_on_start = 1'b0;
    n_cmp++; if (log_q.size() != 2 || log_q[0].cmd !== 2'd0 || log_q[0].data !== 8'h42 ||
                 log_q[1].cmd !== 2'd3) begin
      n_err++; $display("FAIL nack_cmds: got %0d commands (first cmd=%0d data=%h) required START 42 then STOP",
                        log_q.size(), log_q[0].cmd, log_q[0].data); end
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h46) begin n_err++; $display("FAIL nack_status: got %h required 46", s); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL nack_int_masked: got %b required 0", irq); end
    apb_write(8'h05, 8'h04, e);
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h42) begin n_err++; $display("FAIL nack_w1c: got %h required 42", s); end
    apb_write(8'h05, 8'h02, e);
  endtask

  task automatic test_back_to_back;
    logic [7:0] s; logic e;
    log_q.delete();
    apb_write(8'h06, 8'h01, e);
    apb_write(8'h06, 8'h01, e);
    wait_idle("b2b");
    repeat (10) @(negedge clk);
    n_cmp++; if (log_q.size() != 3) begin
      n_err++; $display("FAIL b2b_count: got %0d commands required 3", log_q.size()); end
    n_cmp++; if (log_q.size() >= 2 && (log_q[1].cmd !== 2'd1 || log_q[1].data !== 8'h55)) begin
      n_err++; $display("FAIL b2b_write: got cmd=%0d data=%h required cmd=1 data=55",
                        log_q[1].cmd, log_q[1].data); end
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h52) begin n_err++; $display("FAIL b2b_status: got %h required 52", s); end
    apb_write(8'h05, 8'h02, e);
  endtask

  task automatic test_tx_stall;
    logic [7:0] s; logic e;
    apb_write(8'h02, 8'd2, e);
    apb_write(8'h03, 8'hC3, e);
    log_q.delete();
    apb_write(8'h06, 8'h01, e);
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cvalid !== 1'b0 || log_q.size() != 2) begin
      n_err++; $display("FAIL stall_valid: got valid=%b commands=%0d required valid=0 commands=2",
                        cvalid, log_q.size()); end
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h51) begin n_err++; $display("FAIL stall_status: got %h required 51", s); end
    apb_write(8'h03, 8'hD4, e);
    wait_idle("stall");
    n_cmp++; if (log_q.size() != 4 || log_q[2].cmd !== 2'd1 || log_q[2].data !== 8'hD4 ||
                 log_q[3].cmd !== 2'd3) begin
      n_err++; $display("FAIL stall_resume: got %0d commands required WRITE D4 then STOP (4 total)",
                        log_q.size()); end
    apb_write(8'h05, 8'h02, e);
    for (int i = 1; i <= 5; i++) apb_write(8'h03, 8'(i), e);
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'hC8) begin n_err++; $display("FAIL ovf_status: got %h required C8", s); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] s; logic e;
    int k;
    apb_write(8'h02, 8'd4, e);
    log_q.delete();
    apb_write(8'h06, 8'h01, e);
    k = 0;
    while (log_q.size() < 2 && k < 100) begin @(negedge clk); k++; end
    n_cmp++; if (log_q.size() < 2) begin
      n_err++; $display("FAIL rstm_reach: got %0d commands required 2 (timeout)", log_q.size()); end
    n_cmp++; if (log_q.size() >= 2 && (log_q[1].cmd !== 2'd1 || log_q[1].data !== 8'h01)) begin
      n_err++; $display("FAIL rstm_head: got cmd=%0d data=%h required cmd=1 data=01",
                        log_q[1].cmd, log_q[1].data); end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({cvalid, ccmd, cdata, clast, prdata, pslverr, irq} !== 22'h0) begin
      n_err++; $display("FAIL rstm_outputs: got %h required 0",
                        {cvalid, ccmd, cdata, clast, prdata, pslverr, irq}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (log_q.size() != 2) begin
      n_err++; $display("FAIL rstm_nostop: got %0d commands required 2", log_q.size()); end
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h50) begin n_err++; $display("FAIL rstm_status: got %h required 50", s); end
    apb_read(8'h02, s, e);
    n_cmp++; if (s !== 8'h00) begin n_err++; $display("FAIL rstm_len: got %h required 00", s); end
  endtask

  task automatic test_cmd_ignored;
    logic [7:0] s; logic e;
    apb_write(8'h02, 8'd1, e);
    apb_write(8'h03, 8'h77, e);
    log_q.delete();
    apb_write(8'h06, 8'h01, e);
    repeat (10) @(negedge clk);
    apb_read(8'h05, s, e);
    n_cmp++; if (s !== 8'h40 || log_q.size() != 0) begin
      n_err++; $display("FAIL dis_cmd: got status=%h commands=%0d required status=40 commands=0",
                        s, log_q.size()); end
  endtask

  task automatic test_unmapped;
    logic [7:0] s; logic e;
    apb_read(8'h09, s, e);
    n_cmp++; if (e !== 1'b1 || s !== 8'h00) begin
      n_err++; $display("FAIL unm_read: got err=%b data=%h required err=1 data=00", e, s); end
    apb_write(8'h09, 8'hFF, e);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL unm_write: got err=%b required 1", e); end
    apb_read(8'h07, s, e);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL unm_07: got err=%b required 1", e); end
    apb_read(8'h02, s, e);
    n_cmp++; if (e !== 1'b0 || s !== 8'h01) begin
      n_err++; $display("FAIL map_read: got err=%b data=%h required err=0 data=01", e, s); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_back_to_back();
    test_tx_stall();
    test_reset_mid();
    test_cmd_ignored();
    test_unmapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
